// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
// FIFO entries carry the fetched word alongside the address of the next sequential instruction.
package fetch_pkg;
  localparam int          FETCH_DEPTH    = 4;
  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {IDLE, REQ, DROP} fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-unit bus: instruction-memory req/ack handshake, ID-side redirect/stall and head instruction.
// master = fetch unit; slave = the memory/ID environment around it.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc4;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, pc4,
    input  imem_ack, imem_rdata, redirect, redirect_pc, stall
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, pc4,
    output imem_ack, imem_rdata, redirect, redirect_pc, stall
  );
endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO, DEPTH x 64 bits; a push is visible at the head one cycle later.
// No internal backpressure: callers reserve space before pushing; flush beats push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         push,
  input  fetch_entry_t push_dat,
  input  logic         pop,
  input  logic         flush,
  output logic [CW-1:0] count,
  output fetch_entry_t head
);
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  fetch_entry_t  mem_q [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clock) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_dat;
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];
endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: one-outstanding imem requests feeding a prefetch FIFO toward ID; head valid one cycle after ack.
// ID stall holds the head; issue stops while the FIFO has no free slot; redirect flushes and drops in-flight data.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = FETCH_DEPTH,
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
  input  logic clock,
  input  logic resetn,
  fetch_unit_if.master bus
);
  localparam int          CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_C = CW'(DEPTH - 1);
  localparam logic [31:0] START_PC = RESET_PC & 32'hFFFF_FFFC;

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d, addr_q, addr_d;
  logic          req_q, req_d;
  logic          hold, push_vld, pop_vld;
  logic [31:0]   target;
  logic [CW-1:0] count;
  fetch_entry_t  push_dat, head_dat;

  assign target        = bus.redirect_pc & 32'hFFFF_FFFC;
  assign push_dat.instr = bus.imem_rdata;
  assign push_dat.pc4   = fetch_pc_q + 32'd4;
  assign pop_vld       = (count != '0) && !bus.stall && !bus.redirect;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    push_vld   = 1'b0;
    hold       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.redirect)        fetch_pc_d = target;
        else if (count < FULL_C) state_d    = REQ;
      end
      REQ: begin
        if (bus.redirect) begin
          fetch_pc_d = target;
          state_d    = bus.imem_ack ? REQ : DROP;
          hold       = !bus.imem_ack;
        end else if (bus.imem_ack) begin
          push_vld   = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
          // The push only fills the last slot if nothing leaves this cycle.
          if (count == LAST_C && !pop_vld) state_d = IDLE;
        end else begin
          hold = 1'b1;
        end
      end
      DROP: begin
        if (bus.redirect) fetch_pc_d = target;
        if (bus.imem_ack) state_d = REQ;
        else              hold    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    req_d  = (state_d != IDLE);
    addr_d = hold ? addr_q : fetch_pc_d;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      fetch_pc_q <= START_PC;
      addr_q     <= START_PC;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock    (clock),
    .resetn   (resetn),
    .push     (push_vld),
    .push_dat (push_dat),
    .pop      (pop_vld),
    .flush    (bus.redirect),
    .count    (count),
    .head     (head_dat)
  );

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = addr_q;
  assign bus.instr_valid = (count != '0);
  assign bus.instr       = (count != '0) ? head_dat.instr : 32'h0;
  assign bus.pc4         = (count != '0) ? head_dat.pc4   : 32'h0;
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a transaction-level model (outstanding request + queue).
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clock = 1'b0;
  logic resetn;

  fetch_unit_if bus();

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_bad = 0;

  // Model: FIFO contents {instr, pc4}, next fetch address, and the one outstanding request.
  logic [63:0] q[$];
  logic [31:0] m_pc;
  logic [31:0] m_addr;
  bit          m_out;
  bit          m_drop;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare();
    logic [31:0] e_instr, e_pc4;
    e_instr = (q.size() != 0) ? q[0][63:32] : 32'h0;
    e_pc4   = (q.size() != 0) ? q[0][31:0]  : 32'h0;
    check("imem_req", 32'(bus.imem_req), 32'(m_out));
    if (m_out) check("imem_addr", bus.imem_addr, m_addr);
    check("instr_valid", 32'(bus.instr_valid), 32'(q.size() != 0));
    check("instr", bus.instr, e_instr);
    check("pc4", bus.pc4, e_pc4);
  endtask

  // Check this cycle's outputs, drive inputs, advance the model across the edge.
  task automatic cycle(input bit ack, input logic [31:0] rdata, input bit rd,
                       input logic [31:0] rpc, input bit st);
    bit got, pop;
    int n;
    compare();
    bus.imem_ack    = ack;
    bus.imem_rdata  = rdata;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    bus.stall       = st;
    n   = q.size();
    got = m_out && ack;
    pop = (n != 0) && !st && !rd;
    if (rd)       q.delete();
    else if (pop) void'(q.pop_front());
    if (got && !m_drop && !rd) begin
      q.push_back({rdata, m_addr + 32'd4});
      m_pc = m_addr + 32'd4;
    end
    if (rd) m_pc = rpc & 32'hFFFF_FFFC;
    if (m_out && !got) begin
      m_drop = m_drop | rd;
    end else if (m_out) begin
      m_out  = rd || m_drop || (q.size() < DEPTH);
      m_drop = 1'b0;
      m_addr = m_pc;
    end else begin
      m_out  = !rd && (n < DEPTH);
      m_addr = m_pc;
    end
    @(negedge clock);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #1;
    check("rst_imem_req", 32'(bus.imem_req), 32'h0);
    check("rst_instr_valid", 32'(bus.instr_valid), 32'h0);
    check("rst_instr", bus.instr, 32'h0);
    check("rst_pc4", bus.pc4, 32'h0);
    q.delete();
    m_out  = 1'b0;
    m_drop = 1'b0;
    m_pc   = RESET_PC;
    m_addr = RESET_PC;
    bus.imem_ack = 1'b0; bus.redirect = 1'b0; bus.stall = 1'b0;
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
  endtask

  initial begin
    bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.redirect = 1'b0;
    bus.redirect_pc = '0; bus.stall = 1'b0;
    do_reset();

    // Zero-wait memory: one instruction per cycle; ack in the first idle cycle is ignored.
    for (int i = 0; i < 8; i++) cycle(1'b1, m_addr ^ 32'hA5A5_0000, 1'b0, 32'h0, 1'b0);
    // Stall fills the FIFO and halts issue, then drains.
    for (int i = 0; i < 8; i++) cycle(1'b1, m_addr ^ 32'hA5A5_0000, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 10; i++) cycle(1'b1, m_addr ^ 32'hA5A5_0000, 1'b0, 32'h0, 1'b0);

    // Redirect while a slow request for 8 is pending; the response must be dropped.
    do_reset();
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 32'h1111_0000, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 32'h1111_0004, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 32'h0000_0100, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 32'hDEAD_0008, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, m_addr ^ 32'hA5A5_0000, 1'b0, 32'h0, 1'b0);
    // Redirect coinciding with an ack: data discarded, fetch resumes at 0x40.
    cycle(1'b1, 32'hBAD0_BAD0, 1'b1, 32'h0000_0040, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, m_addr ^ 32'hA5A5_0000, 1'b0, 32'h0, 1'b0);
    // Address wraparound, with an unaligned target.
    cycle(1'b1, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, m_addr ^ 32'hA5A5_0000, 1'b0, 32'h0, 1'b0);
    // Reset mid-request with entries buffered.
    for (int i = 0; i < 4; i++) cycle(1'b1, m_addr ^ 32'hA5A5_0000, 1'b0, 32'h0, 1'b1);
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, m_addr ^ 32'hA5A5_0000, 1'b0, 32'h0, 1'b0);

    // Random phases sweeping ack latency, stall pressure and redirect rate.
    for (int ph = 0; ph < 6; ph++) begin
      int ack_p, st_p, rd_p;
      ack_p = 15 + ph * 17;
      st_p  = (ph % 3) * 35;
      rd_p  = 2 + (ph % 2) * 10;
      for (int i = 0; i < 400; i++) begin
        bit a, s, r;
        logic [31:0] rpc;
        a   = ($urandom_range(99) < ack_p);
        s   = ($urandom_range(99) < st_p);
        r   = ($urandom_range(99) < rd_p);
        rpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(15))) : $urandom;
        cycle(a, $urandom, r, rpc, s);
      end
      if (ph == 3) do_reset();
    end

    compare();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
